// File: rtl/alarm_clock_core.sv
// Purpose : MM:SS clock with a settable MM:SS alarm and ring/snooze state machine,
//           emitting eight active-low seven-segment digit codes {a..g,dp}.
// Latency : digit outputs and alarmOn are registered, 1 cycle after the state that drives them.
// Backpressure: none; free-running source, inputs are level/pulse controls sampled each cycle.
//
// Ports:
//   Clock, resetSW (async, active-low)
//   run, setTime, setAlarm, incSec, incMin, alarmEn, alarmAck  - control inputs
//   BCDos/BCDts/BCDom/BCDtm      - time digits   (ones sec, tens sec, ones min, tens min)
//   BCDaos/BCDats/BCDaom/BCDatm  - alarm digits  (same order)
//   alarmOn                      - high while the alarm is ringing
//
// Build option: define SNOOZE_EN to turn alarmAck during a ring into a timed snooze
// instead of a dismiss.

module alarm_clock_core #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int RING_SECS     = 30,
   parameter int SNOOZE_SECS   = 60
) (
   input  logic       Clock,
   input  logic       resetSW,
   input  logic       run,
   input  logic       setTime,
   input  logic       setAlarm,
   input  logic       incSec,
   input  logic       incMin,
   input  logic       alarmEn,
   input  logic       alarmAck,
   output logic [7:0] BCDos,
   output logic [7:0] BCDts,
   output logic [7:0] BCDom,
   output logic [7:0] BCDtm,
   output logic [7:0] BCDaos,
   output logic [7:0] BCDats,
   output logic [7:0] BCDaom,
   output logic [7:0] BCDatm,
   output logic       alarmOn
);

   // Elaboration-time parameter range checks.
   if (TICKS_PER_SEC < 2) begin : g_bad_ticks
      $error("TICKS_PER_SEC must be >= 2");
   end
   if (RING_SECS < 1 || RING_SECS > 255) begin : g_bad_ring
      $error("RING_SECS must be 1..255");
   end
   if (SNOOZE_SECS < 1 || SNOOZE_SECS > 255) begin : g_bad_snooze
      $error("SNOOZE_SECS must be 1..255");
   end

   localparam int             PW        = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0]     RING_LIM  = 8'(RING_SECS);
`ifdef SNOOZE_EN
   localparam logic [7:0]     SNZ_LIM   = 8'(SNOOZE_SECS);
`endif
   localparam logic [7:0]     SEG_ZERO  = 8'b00000011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1
`ifdef SNOOZE_EN
      ,
      ST_SNOOZE  = 2'd2
`endif
   } state_t;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   // Packed BCD {tens,ones} increment, 59 wraps to 00.
   function automatic logic [7:0] inc60(input logic [7:0] v);
      logic [7:0] r;
      r = v;
      if (v[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         if (v[7:4] == 4'd5) r[7:4] = 4'd0;
         else                r[7:4] = v[7:4] + 4'd1;
      end else begin
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

   // Active-low {a,b,c,d,e,f,g,dp}; dp held off.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'b00000011;
         4'd1:    s = 8'b10011111;
         4'd2:    s = 8'b00100101;
         4'd3:    s = 8'b00001101;
         4'd4:    s = 8'b10011001;
         4'd5:    s = 8'b01001001;
         4'd6:    s = 8'b01000001;
         4'd7:    s = 8'b00011111;
         4'd8:    s = 8'b00000001;
         4'd9:    s = 8'b00001001;
         default: s = 8'b11111111;
      endcase
      return s;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    tsec_q, tsec_d, tmin_q, tmin_d;   // time  {tens,ones}
   logic [7:0]    asec_q, asec_d, amin_q, amin_d;   // alarm {tens,ones}
   state_t        state_q, state_d;
   logic [7:0]    ring_cnt_q, ring_cnt_d;
`ifdef SNOOZE_EN
   logic [7:0]    snz_cnt_q, snz_cnt_d;
`endif
   logic          alarm_on_q, alarm_on_d;
   logic [7:0]    seg_os_q, seg_ts_q, seg_om_q, seg_tm_q;
   logic [7:0]    seg_aos_q, seg_ats_q, seg_aom_q, seg_atm_q;
   logic [7:0]    seg_os_d, seg_ts_d, seg_om_d, seg_tm_d;
   logic [7:0]    seg_aos_d, seg_ats_d, seg_aom_d, seg_atm_d;

   logic tick;
   logic match;

   // ------------------------------------------------------------------
   // Prescaler: frozen by run=0, held at zero during time-set so the first
   // second after leaving set mode is a full second.
   // ------------------------------------------------------------------
   always_comb begin
      tick    = run && !setTime && (presc_q == PRESC_MAX);
      presc_d = presc_q;
      if (setTime)    presc_d = '0;
      else if (tick)  presc_d = '0;
      else if (run)   presc_d = presc_q + PW'(1);
   end

   // ------------------------------------------------------------------
   // Time and alarm registers
   // ------------------------------------------------------------------
   always_comb begin
      tsec_d = tsec_q;
      tmin_d = tmin_q;
      asec_d = asec_q;
      amin_d = amin_q;

      // tick is already suppressed while setTime=1, so the branches are exclusive.
      if (setTime) begin
         if (incSec) tsec_d = inc60(tsec_q);
         if (incMin) tmin_d = inc60(tmin_q);
      end else if (tick) begin
         tsec_d = inc60(tsec_q);
         if (tsec_q == 8'h59) tmin_d = inc60(tmin_q);
      end

      if (setAlarm && !setTime) begin
         if (incSec) asec_d = inc60(asec_q);
         if (incMin) amin_d = inc60(amin_q);
      end
   end

   // Only a counting tick can create a match; manual edits never do.
   assign match = tick && alarmEn && !setAlarm &&
                  ({tmin_d, tsec_d} == {amin_q, asec_q});

   // ------------------------------------------------------------------
   // Alarm FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge Clock or negedge resetSW) begin
      if (!resetSW) begin
         state_q    <= ST_IDLE;
         ring_cnt_q <= '0;
`ifdef SNOOZE_EN
         snz_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
`ifdef SNOOZE_EN
         snz_cnt_q  <= snz_cnt_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Alarm FSM: next state. Exit priority while ringing is
   // alarmEn low, then alarmAck, then ring timeout.
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
`ifdef SNOOZE_EN
      snz_cnt_d  = snz_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (match) begin
               state_d    = ST_RINGING;
               ring_cnt_d = '0;
            end
         end
         ST_RINGING: begin
            if (!alarmEn) begin
               state_d = ST_IDLE;
            end else if (alarmAck) begin
`ifdef SNOOZE_EN
               state_d   = ST_SNOOZE;
               snz_cnt_d = '0;
`else
               state_d   = ST_IDLE;
`endif
            end else if (tick) begin
               if (ring_cnt_q + 8'd1 == RING_LIM) state_d = ST_IDLE;
               else                               ring_cnt_d = ring_cnt_q + 8'd1;
            end
         end
`ifdef SNOOZE_EN
         ST_SNOOZE: begin
            if (!alarmEn) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (snz_cnt_q + 8'd1 == SNZ_LIM) begin
                  state_d    = ST_RINGING;
                  ring_cnt_d = '0;
               end else begin
                  snz_cnt_d  = snz_cnt_q + 8'd1;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: alarmOn follows the next state so it rises in the cycle
   // right after the matching tick; digits encode the current registers.
   // ------------------------------------------------------------------
   always_comb begin
      alarm_on_d = (state_d == ST_RINGING);
      seg_os_d   = seg7(tsec_q[3:0]);
      seg_ts_d   = seg7(tsec_q[7:4]);
      seg_om_d   = seg7(tmin_q[3:0]);
      seg_tm_d   = seg7(tmin_q[7:4]);
      seg_aos_d  = seg7(asec_q[3:0]);
      seg_ats_d  = seg7(asec_q[7:4]);
      seg_aom_d  = seg7(amin_q[3:0]);
      seg_atm_d  = seg7(amin_q[7:4]);
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge Clock or negedge resetSW) begin
      if (!resetSW) begin
         presc_q    <= '0;
         tsec_q     <= '0;
         tmin_q     <= '0;
         asec_q     <= '0;
         amin_q     <= '0;
         alarm_on_q <= 1'b0;
         seg_os_q   <= SEG_ZERO;
         seg_ts_q   <= SEG_ZERO;
         seg_om_q   <= SEG_ZERO;
         seg_tm_q   <= SEG_ZERO;
         seg_aos_q  <= SEG_ZERO;
         seg_ats_q  <= SEG_ZERO;
         seg_aom_q  <= SEG_ZERO;
         seg_atm_q  <= SEG_ZERO;
      end else begin
         presc_q    <= presc_d;
         tsec_q     <= tsec_d;
         tmin_q     <= tmin_d;
         asec_q     <= asec_d;
         amin_q     <= amin_d;
         alarm_on_q <= alarm_on_d;
         seg_os_q   <= seg_os_d;
         seg_ts_q   <= seg_ts_d;
         seg_om_q   <= seg_om_d;
         seg_tm_q   <= seg_tm_d;
         seg_aos_q  <= seg_aos_d;
         seg_ats_q  <= seg_ats_d;
         seg_aom_q  <= seg_aom_d;
         seg_atm_q  <= seg_atm_d;
      end
   end

   assign BCDos   = seg_os_q;
   assign BCDts   = seg_ts_q;
   assign BCDom   = seg_om_q;
   assign BCDtm   = seg_tm_q;
   assign BCDaos  = seg_aos_q;
   assign BCDats  = seg_ats_q;
   assign BCDaom  = seg_aom_q;
   assign BCDatm  = seg_atm_q;
   assign alarmOn = alarm_on_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Purpose : directed bench for alarm_clock_core with a 4-cycle second.
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.

module tb_alarm_clock_core;

   logic       Clock = 1'b0;
   logic       resetSW, run, setTime, setAlarm, incSec, incMin, alarmEn, alarmAck;
   logic [7:0] BCDos, BCDts, BCDom, BCDtm, BCDaos, BCDats, BCDaom, BCDatm;
   logic       alarmOn;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [7:0] SEG [0:9] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

   alarm_clock_core #(
      .TICKS_PER_SEC (4),
      .RING_SECS     (3),
      .SNOOZE_SECS   (2)
   ) dut (
      .Clock    (Clock),
      .resetSW  (resetSW),
      .run      (run),
      .setTime  (setTime),
      .setAlarm (setAlarm),
      .incSec   (incSec),
      .incMin   (incMin),
      .alarmEn  (alarmEn),
      .alarmAck (alarmAck),
      .BCDos    (BCDos),
      .BCDts    (BCDts),
      .BCDom    (BCDom),
      .BCDtm    (BCDtm),
      .BCDaos   (BCDaos),
      .BCDats   (BCDats),
      .BCDaom   (BCDaom),
      .BCDatm   (BCDatm),
      .alarmOn  (alarmOn)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic check_time(input string tag, input int mt, input int mo, input int st, input int so);
      chk({tag, ".tm"}, BCDtm, SEG[mt]);
      chk({tag, ".om"}, BCDom, SEG[mo]);
      chk({tag, ".ts"}, BCDts, SEG[st]);
      chk({tag, ".os"}, BCDos, SEG[so]);
   endtask

   task automatic check_alarm(input string tag, input int mt, input int mo, input int st, input int so);
      chk({tag, ".atm"}, BCDatm, SEG[mt]);
      chk({tag, ".aom"}, BCDaom, SEG[mo]);
      chk({tag, ".ats"}, BCDats, SEG[st]);
      chk({tag, ".aos"}, BCDaos, SEG[so]);
   endtask

   task automatic check_on(input string tag, input logic exp);
      chk(tag, 8'(alarmOn), 8'(exp));
   endtask

   task automatic pulse_inc(input logic s, input logic m);
      incSec = s;
      incMin = m;
      cyc(1);
      incSec = 1'b0;
      incMin = 1'b0;
      cyc(1);
   endtask

   task automatic do_reset();
      resetSW  = 1'b0;
      run      = 1'b0;
      setTime  = 1'b0;
      setAlarm = 1'b0;
      incSec   = 1'b0;
      incMin   = 1'b0;
      alarmEn  = 1'b0;
      alarmAck = 1'b0;
      cyc(2);
      resetSW  = 1'b1;
   endtask

   // Alarm at 00:02, armed, time running from 00:00 with prescaler at 0.
   task automatic arm_alarm2();
      do_reset();
      setAlarm = 1'b1;
      pulse_inc(1'b1, 1'b0);
      pulse_inc(1'b1, 1'b0);
      setAlarm = 1'b0;
      alarmEn  = 1'b1;
      run      = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      resetSW = 1'b0; run = 1'b0; setTime = 1'b0; setAlarm = 1'b0;
      incSec = 1'b0; incMin = 1'b0; alarmEn = 1'b0; alarmAck = 1'b0;
      cyc(2);
      check_time("rst", 0, 0, 0, 0);
      check_alarm("rst", 0, 0, 0, 0);
      check_on("rst.on", 1'b0);

      // ---------------- 60 seconds of counting ----------------
      resetSW = 1'b1;
      run     = 1'b1;
      cyc(240);                       // regs just became 01:00, display one behind
      check_time("t239", 0, 0, 5, 9);
      cyc(1);
      check_time("t01_00", 0, 1, 0, 0);
      run = 1'b0;
      cyc(10);
      check_time("frozen", 0, 1, 0, 0);

      // ---------------- time set and 59:59 wrap ----------------
      do_reset();
      setTime = 1'b1;
      run     = 1'b1;                 // must not tick while setting
      for (int i = 0; i < 59; i++) pulse_inc(1'b1, 1'b0);
      for (int i = 0; i < 58; i++) pulse_inc(1'b0, 1'b1);
      check_time("set58_59", 5, 8, 5, 9);
      pulse_inc(1'b1, 1'b0);          // seconds wrap, no carry into minutes
      check_time("set58_00", 5, 8, 0, 0);
      pulse_inc(1'b1, 1'b1);          // both fields in one cycle
      check_time("set59_01", 5, 9, 0, 1);
      for (int i = 0; i < 58; i++) pulse_inc(1'b1, 1'b0);
      check_time("set59_59", 5, 9, 5, 9);
      setTime = 1'b0;
      cyc(4);
      check_time("pre_wrap", 5, 9, 5, 9);
      cyc(1);
      check_time("wrap", 0, 0, 0, 0);

      // ---------------- alarm ring and timeout ----------------
      arm_alarm2();
      check_alarm("alm00_02", 0, 0, 0, 2);
      cyc(7);
      check_on("ring.pre", 1'b0);
      cyc(1);
      check_on("ring.rise", 1'b1);
      check_time("ring.disp", 0, 0, 0, 1);
      cyc(11);
      check_on("ring.hold", 1'b1);
      cyc(1);
      check_on("ring.timeout", 1'b0);

      // ---------------- acknowledge ----------------
      arm_alarm2();
      cyc(8);
      check_on("ack.ring", 1'b1);
      alarmAck = 1'b1;
      cyc(1);
      alarmAck = 1'b0;
      check_on("ack.off", 1'b0);
`ifdef SNOOZE_EN
      cyc(6);
      check_on("snz.quiet", 1'b0);
      cyc(1);
      check_on("snz.rering", 1'b1);
      alarmAck = 1'b1;
      cyc(1);
      alarmAck = 1'b0;
      check_on("snz.ack2", 1'b0);
      alarmEn = 1'b0;
      cyc(12);
      check_on("snz.disarm", 1'b0);
`else
      cyc(12);
      check_on("ack.stay", 1'b0);
`endif

      // ---------------- alarmEn dropped with alarmAck ----------------
      arm_alarm2();
      cyc(8);
      check_on("dis.ring", 1'b1);
      alarmEn  = 1'b0;
      alarmAck = 1'b1;
      cyc(1);
      alarmAck = 1'b0;
      check_on("dis.off", 1'b0);
      cyc(12);
      check_on("dis.stay", 1'b0);

      // ---------------- edits never cause a match ----------------
      do_reset();
      alarmEn  = 1'b1;
      setAlarm = 1'b1;
      run      = 1'b1;
      pulse_inc(1'b1, 1'b0);
      pulse_inc(1'b1, 1'b0);          // alarm 00:02, time passes it below
      cyc(8);
      check_on("edit.setalarm", 1'b0);
      run      = 1'b0;                // time held at 00:03
      setAlarm = 1'b1;
      pulse_inc(1'b1, 1'b0);          // alarm becomes equal to time
      setAlarm = 1'b0;
      cyc(4);
      check_on("edit.equal", 1'b0);
      check_time("edit.time", 0, 0, 0, 3);
      check_alarm("edit.alm", 0, 0, 0, 3);
      run = 1'b1;
      cyc(5);
      check_time("edit.next", 0, 0, 0, 4);
      check_on("edit.next_on", 1'b0);

      // ---------------- async reset while ringing ----------------
      run      = 1'b0;                // prescaler held at 1
      setAlarm = 1'b1;
      pulse_inc(1'b1, 1'b0);
      pulse_inc(1'b1, 1'b0);          // alarm 00:05
      setAlarm = 1'b0;
      run      = 1'b1;
      cyc(3);
      check_on("arst.ring", 1'b1);
      #2;
      resetSW = 1'b0;
      #1;
      check_on("arst.on", 1'b0);
      check_time("arst", 0, 0, 0, 0);
      check_alarm("arst", 0, 0, 0, 0);
      cyc(2);
      resetSW = 1'b1;
      run     = 1'b1;
      alarmEn = 1'b1;
      cyc(12);
      check_on("arst.nopending", 1'b0);
      check_time("arst.run", 0, 0, 0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alarm_clock_core.md
Name: alarm_clock_core

Overview:
- Timekeeping source for the eight-digit display multiplexer: produces the MM:SS time digits and the MM:SS alarm digits as 8-bit segment codes.
- Counts seconds from an internal prescaler. Accepts debounced set/increment pulses and runs an alarm state machine that drives alarmOn.
- Sits directly upstream of the 8-digit seven-segment scan controller and feeds its eight digit inputs.

Parameters:
- TICKS_PER_SEC, 100000000, Clock cycles per one-second tick (≥2).
- RING_SECS, 30, seconds RINGING lasts before auto-timeout (1..255).
- SNOOZE_SECS, 60, snooze length in seconds (1..255; used only with SNOOZE_EN).

Ports:
- Clock  in  1  system clock, all state on rising edge
- resetSW  in  1  asynchronous, active-low reset
- run  in  1  1 = time counts; 0 = prescaler and time frozen
- setTime  in  1  level; time-set mode (time frozen, increments go to time)
- setAlarm  in  1  level; alarm-set mode (increments go to alarm)
- incSec  in  1  one-cycle pulse (pre-debounced), increment selected seconds
- incMin  in  1  one-cycle pulse, increment selected minutes
- alarmEn  in  1  level; alarm armed
- alarmAck  in  1  one-cycle pulse; dismiss (or snooze) ringing alarm
- BCDos, BCDts, BCDom, BCDtm  out  8 each  time digits: ones sec, tens sec, ones min, tens min
- BCDaos, BCDats, BCDaom, BCDatm  out  8 each  alarm digits, same order
- alarmOn  out  1  1 while RINGING

Behaviour:
- Reset (resetSW=0, asynchronous):
  - Time and alarm registers = 00:00; prescaler = 0.
  - FSM = IDLE; alarmOn = 0.
  - All eight digit outputs = 8'b00000011 (glyph "0").
- Segment code format: {a,b,c,d,e,f,g,dp}, active-low, dp always 1.
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001.
  - Any non-BCD nibble encodes to 11111111 (blank). This must be unreachable.
- Digit outputs are registered: each reflects the BCD registers with exactly 1 cycle of latency.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while run=1 and setTime=0.
  - tick asserts for one cycle when the count is TICKS_PER_SEC-1; the count then wraps to 0.
  - When run=0 the prescaler holds its value. When setTime=1 it is cleared to 0.
- Time counting on tick:
  - Seconds are BCD 00..59. 59 wraps to 00 and carries into minutes.
  - Minutes are BCD 00..59. 59:59 wraps to 00:00.
  - Ones digit 9 → 0 with carry into the tens digit; tens digit 5 → 0 with carry out.
- Set modes:
  - setTime=1: incSec adds 1 to the time seconds and incMin adds 1 to the time minutes. Each wraps 59→00 with no carry between fields.
  - setAlarm=1 (and setTime=0): the same increments apply to the alarm registers. Time keeps running in this mode.
  - Both set inputs high: setTime has priority.
  - Neither high: incSec and incMin are ignored.
  - incSec and incMin in the same cycle: both fields increment.
- Alarm FSM, states IDLE, RINGING, SNOOZE:
  - Match: a cycle in which tick updates time to a value equal to the alarm value, alarmEn=1 and setAlarm=0. Setting the time or alarm to an equal value never creates a match.
  - IDLE→RINGING on match. A ring-second counter loads 0.
  - RINGING: alarmOn=1. The ring-second counter increments on each tick.
    - alarmEn=0 → IDLE.
    - alarmAck → IDLE (see SNOOZE_EN for the alternative).
    - Counter reaching RING_SECS → IDLE.
    - Priority: alarmEn=0 > alarmAck > timeout.
  - alarmOn is registered and goes high in the cycle after the match tick.
  - A new match while RINGING has no effect.
- Reset mid-operation: all state returns to reset values immediately. There is no pending ring after release.

Optional Feature:
- Macro SNOOZE_EN.
- Defined: alarmAck in RINGING → SNOOZE (alarmOn=0); a snooze counter loads 0 and counts ticks.
  - Counter reaching SNOOZE_SECS → RINGING with the ring counter reloaded to 0.
  - alarmEn=0 in SNOOZE → IDLE.
  - alarmAck in SNOOZE is ignored.
- Undefined: the SNOOZE state and its counter do not exist; alarmAck in RINGING → IDLE.

Test Plan (TICKS_PER_SEC=4, RING_SECS=3, SNOOZE_SECS=2):
- Reset, then run=1 for 4×60 cycles → time 01:00. BCDom=10011111 and the other three time digits are 00000011, each 1 cycle after the update.
- setTime with 59 incSec pulses and 59 incMin pulses, then run → display 59:59. The next tick gives 00:00, and no tick occurs while setTime=1.
- setAlarm with 2 incSec pulses (alarm 00:02) and alarmEn=1, reset time, run → alarmOn=1 the cycle after time becomes 00:02. alarmOn=0 after 3 further ticks with no ack.
- Ringing, then alarmAck → alarmOn=0 next cycle, and it stays 0 through 00:02 repeat-free seconds. Also: alarmEn dropped together with alarmAck → IDLE.
- Edit the alarm to equal the current time while setAlarm=1 → no ring. Assert resetSW=0 while RINGING → alarmOn=0 asynchronously and all digits = 00000011.
- (SNOOZE_EN) ack while ringing → alarmOn=0 for 2 ticks, then 1 again. alarmEn=0 during SNOOZE → IDLE, with no re-ring.
